// File: rtl/cnn_pool_pkg.sv
// Shared types and constants for the streaming KxK pooling block:
// mode encoding, fixed-point reciprocal constants and counter sizing.
package cnn_pool_pkg;

    typedef enum logic {
        POOL_AVG = 1'b0,
        POOL_MAX = 1'b1
    } pool_mode_e;

    localparam int RECIP_SHIFT = 16;
    localparam int RECIP_ROUND = 32768;
    localparam int RECIP_W     = 17;

    // round(2^16 / (k*k)) in integer arithmetic
    function automatic int recip_for(input int k);
        return ((1 << RECIP_SHIFT) + ((k * k) / 2)) / (k * k);
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Row storage for KERNEL-1 previous rows plus per-channel column history,
// presenting the KERNEL*KERNEL window (row-major, oldest row/column first).
module pool_line_buffer
    import cnn_pool_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int IMAGE_WIDTH = 8,
    parameter int CHANNEL_NUM = 4,
    parameter int KERNEL      = 3,
    localparam int CHW        = cnt_w(CHANNEL_NUM),
    localparam int COLW       = cnt_w(IMAGE_WIDTH)
) (
    input  logic                                 clk,
    input  logic                                 we_i,
    input  logic [CHW-1:0]                       ch_i,
    input  logic [COLW-1:0]                      col_i,
    input  logic [DATA_WIDTH-1:0]                pxl_i,
    output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  taps_o
);

    localparam int DEPTH = IMAGE_WIDTH * CHANNEL_NUM;
    localparam int AW    = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] lb_q  [KERNEL-1][DEPTH];
    logic [DATA_WIDTH-1:0] win_q [CHANNEL_NUM][KERNEL][KERNEL-1];
    logic [DATA_WIDTH-1:0] col_s [KERNEL];
    logic [AW-1:0]         addr_s;

    assign addr_s = AW'(col_i) * AW'(CHANNEL_NUM) + AW'(ch_i);

    // Newest column comes from the stored rows plus the live sample; older columns from history.
    always_comb begin
        taps_o = '0;
        for (int r = 0; r < KERNEL - 1; r++) begin
            col_s[r] = lb_q[KERNEL-2-r][addr_s];
        end
        col_s[KERNEL-1] = pxl_i;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                taps_o[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[ch_i][r][c];
            end
            taps_o[(r*KERNEL+KERNEL-1)*DATA_WIDTH +: DATA_WIDTH] = col_s[r];
        end
    end

    // Rows shift down one line and the channel's column history shifts left on every beat.
    always_ff @(posedge clk) begin
        if (we_i) begin
            lb_q[0][addr_s] <= pxl_i;
            for (int i = 1; i < KERNEL - 1; i++) begin
                lb_q[i][addr_s] <= lb_q[i-1][addr_s];
            end
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 2; c++) begin
                    win_q[ch_i][r][c] <= win_q[ch_i][r][c+1];
                end
                win_q[ch_i][r][KERNEL-2] <= col_s[r];
            end
        end
    end

endmodule

// File: rtl/cnn_pool_kxk_stream.sv
// Streaming KxK average pooling over a channel-interleaved frame, 3-cycle latency.
// Define POOL_MAX_MODE_EN to add the max datapath and the frame-sampled mode register.
module cnn_pool_kxk_stream
    import cnn_pool_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int CHANNEL_NUM  = 4,
    parameter int KERNEL       = 3,
    parameter int STRIDE       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int   CHW      = cnt_w(CHANNEL_NUM);
    localparam int   COLW     = cnt_w(IMAGE_WIDTH);
    localparam int   ROWW     = cnt_w(IMAGE_HEIGHT);
    localparam int   NTAP     = KERNEL * KERNEL;
    localparam int   SUMW     = DATA_WIDTH + 4;
    localparam int   PRODW    = SUMW + RECIP_W;
    localparam int   QW       = PRODW - RECIP_SHIFT;
    localparam int   RECIP    = recip_for(KERNEL);
    localparam int   KM1      = KERNEL - 1;
    localparam logic KM1_ODD  = 1'((KERNEL - 1) % 2);
    localparam int   LAST_ROW = KM1 + STRIDE * ((IMAGE_HEIGHT - KERNEL) / STRIDE);
    localparam int   LAST_COL = KM1 + STRIDE * ((IMAGE_WIDTH - KERNEL) / STRIDE);

    logic [CHW-1:0]             ch_q, ch_d;
    logic [COLW-1:0]            col_q, col_d;
    logic [ROWW-1:0]            row_q, row_d;
    logic                       last_ch_s, last_col_s, last_row_s;
    logic                       win_s, win_last_s;
    logic [NTAP*DATA_WIDTH-1:0] taps_s, taps1_q;
    logic                       v1_q, last1_q, v2_q, last2_q;
    logic [SUMW-1:0]            sum_s, sum2_q;
    logic [PRODW-1:0]           prod_s;
    logic [QW-1:0]              quot_s;
    logic [DATA_WIDTH-1:0]      avg_s, res_s;
    logic                       valid_out_q, frame_done_q;
    logic [DATA_WIDTH-1:0]      pxl_out_q;
`ifdef POOL_MAX_MODE_EN
    pool_mode_e                 mode_q, mode1_q, mode2_q;
    logic [DATA_WIDTH-1:0]      max_s;
    logic                       first_s;
    assign first_s = (ch_q == '0) && (col_q == '0) && (row_q == '0);
`else
    logic                       unused_mode_s;
    assign unused_mode_s = mode;
`endif

    assign last_ch_s  = (ch_q  == CHW'(CHANNEL_NUM - 1));
    assign last_col_s = (col_q == COLW'(IMAGE_WIDTH - 1));
    assign last_row_s = (row_q == ROWW'(IMAGE_HEIGHT - 1));

    // No padding: a window closes on the bottom-right sample of an aligned KxK block.
    assign win_s = valid_in
                && (row_q >= ROWW'(KM1)) && ((STRIDE == 1) || (row_q[0] == KM1_ODD))
                && (col_q >= COLW'(KM1)) && ((STRIDE == 1) || (col_q[0] == KM1_ODD));
    assign win_last_s = win_s && last_ch_s
                     && (row_q == ROWW'(LAST_ROW)) && (col_q == COLW'(LAST_COL));

    pool_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMAGE_WIDTH(IMAGE_WIDTH),
        .CHANNEL_NUM(CHANNEL_NUM),
        .KERNEL     (KERNEL)
    ) u_line_buffer (
        .clk   (clk),
        .we_i  (valid_in),
        .ch_i  (ch_q),
        .col_i (col_q),
        .pxl_i (pxl_in),
        .taps_o(taps_s)
    );

    // Channel-fastest position counters, advancing only on accepted beats.
    always_comb begin
        ch_d  = ch_q;
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (last_ch_s) begin
                ch_d = '0;
                if (last_col_s) begin
                    col_d = '0;
                    if (last_row_s) begin
                        row_d = '0;
                    end else begin
                        row_d = row_q + ROWW'(1);
                    end
                end else begin
                    col_d = col_q + COLW'(1);
                end
            end else begin
                ch_d = ch_q + CHW'(1);
            end
        end else begin
            ch_d = ch_q;
        end
    end

    // Window reduction: exact sum, plus unsigned max when that datapath is built.
    always_comb begin
        sum_s = '0;
`ifdef POOL_MAX_MODE_EN
        max_s = '0;
`endif
        for (int i = 0; i < NTAP; i++) begin
            sum_s = sum_s + SUMW'(taps1_q[i*DATA_WIDTH +: DATA_WIDTH]);
`ifdef POOL_MAX_MODE_EN
            max_s = (taps1_q[i*DATA_WIDTH +: DATA_WIDTH] > max_s)
                  ? taps1_q[i*DATA_WIDTH +: DATA_WIDTH] : max_s;
`endif
        end
    end

    // Reciprocal multiply with round-half-up, saturated to the pixel range.
    always_comb begin
        prod_s = PRODW'(sum2_q) * PRODW'(RECIP) + PRODW'(RECIP_ROUND);
        quot_s = QW'(prod_s >> RECIP_SHIFT);
        if (|quot_s[QW-1:DATA_WIDTH]) begin
            avg_s = '1;
        end else begin
            avg_s = quot_s[DATA_WIDTH-1:0];
        end
`ifdef POOL_MAX_MODE_EN
        if (mode2_q == POOL_MAX) begin
            res_s = sum2_q[DATA_WIDTH-1:0];
        end else begin
            res_s = avg_s;
        end
`else
        res_s = avg_s;
`endif
    end

    // Counters, frame-sampled mode and the three-stage result pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            v1_q         <= 1'b0;
            last1_q      <= 1'b0;
            taps1_q      <= '0;
            v2_q         <= 1'b0;
            last2_q      <= 1'b0;
            sum2_q       <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pxl_out_q    <= '0;
`ifdef POOL_MAX_MODE_EN
            mode_q       <= POOL_AVG;
            mode1_q      <= POOL_AVG;
            mode2_q      <= POOL_AVG;
`endif
        end else begin
            ch_q         <= ch_d;
            col_q        <= col_d;
            row_q        <= row_d;
            v1_q         <= win_s;
            last1_q      <= win_last_s;
            if (win_s) begin
                taps1_q <= taps_s;
            end
            v2_q         <= v1_q;
            last2_q      <= v1_q & last1_q;
            valid_out_q  <= v2_q;
            frame_done_q <= v2_q & last2_q;
            if (v2_q) begin
                pxl_out_q <= res_s;
            end
`ifdef POOL_MAX_MODE_EN
            if (valid_in && first_s) begin
                mode_q <= pool_mode_e'(mode);
            end
            if (win_s) begin
                mode1_q <= mode_q;
            end
            mode2_q <= mode1_q;
            sum2_q  <= (mode1_q == POOL_MAX) ? SUMW'(max_s) : sum_s;
`else
            sum2_q  <= sum_s;
`endif
        end
    end

    assign pxl_out    = pxl_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_pool_kxk_stream.sv
// Scoreboard bench: three pooling configurations driven with directed 4x4 frames.
module tb_cnn_pool_kxk_stream;

    typedef struct {
        logic [15:0] val;
        int          cyc;
        bit          fd;
    } exp_t;

`ifdef POOL_MAX_MODE_EN
    localparam bit MAXEN = 1'b1;
`else
    localparam bit MAXEN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        vin [3];
    logic [15:0] pin [3];
    logic        md  [3];
    logic [15:0] po0, po1, po2;
    logic        vo0, vo1, vo2, fd0, fd1, fd2;
    logic [15:0] px [32];
    logic [15:0] ev_max_a [8];
    logic [15:0] ev_max_b [8];
    exp_t        q0[$], q1[$], q2[$];
    int          cyc    = 0;
    int          n_run  = 0;
    int          n_fail = 0;

    // A: 4x4, 1 ch, K3 S1   B: 4x4, 1 ch, K2 S2   C: 4x4, 2 ch, K3 S1
    cnn_pool_kxk_stream #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
                          .CHANNEL_NUM(1), .KERNEL(3), .STRIDE(1)) u_a (
        .clk(clk), .reset(reset), .valid_in(vin[0]), .pxl_in(pin[0]), .mode(md[0]),
        .pxl_out(po0), .valid_out(vo0), .frame_done(fd0));
    cnn_pool_kxk_stream #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
                          .CHANNEL_NUM(1), .KERNEL(2), .STRIDE(2)) u_b (
        .clk(clk), .reset(reset), .valid_in(vin[1]), .pxl_in(pin[1]), .mode(md[1]),
        .pxl_out(po1), .valid_out(vo1), .frame_done(fd1));
    cnn_pool_kxk_stream #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
                          .CHANNEL_NUM(2), .KERNEL(3), .STRIDE(1)) u_c (
        .clk(clk), .reset(reset), .valid_in(vin[2]), .pxl_in(pin[2]), .mode(md[2]),
        .pxl_out(po2), .valid_out(vo2), .frame_done(fd2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int inst, input exp_t e);
        case (inst)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic check(input int inst, input logic v, input logic [15:0] p, input logic f);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '{16'd0, 0, 1'b0};
        if (v === 1'b1) begin
            n_run++;
            case (inst)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                n_fail++;
                $display("FAIL out_unexpected inst%0d: got %0d at cycle %0d, required no output",
                         inst, p, cyc);
            end else if (p !== e.val || f !== e.fd || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL out_value inst%0d: got val=%0d fd=%0b cyc=%0d, required val=%0d fd=%0b cyc=%0d",
                         inst, p, f, cyc, e.val, e.fd, e.cyc);
            end
        end else if (f !== 1'b0) begin
            n_run++;
            n_fail++;
            $display("FAIL stray_frame_done inst%0d: got frame_done=%0b without valid_out, required 0", inst, f);
        end
    endtask

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge clk) begin
        check(0, vo0, po0, fd0);
        check(1, vo1, po1, fd1);
        check(2, vo2, po2, fd2);
    end

    task automatic check_zero(input int inst, input logic [15:0] p, input logic v, input logic f);
        n_run += 3;
        if (p !== 16'd0) begin n_fail++; $display("FAIL reset_pxl inst%0d: got %0d, required 0", inst, p); end
        if (v !== 1'b0)  begin n_fail++; $display("FAIL reset_valid inst%0d: got %0b, required 0", inst, v); end
        if (f !== 1'b0)  begin n_fail++; $display("FAIL reset_done inst%0d: got %0b, required 0", inst, f); end
    endtask

    // Drive n beats from px; beats listed in wb are window-complete and expect ev three cycles later.
    task automatic run_frame(input int inst, input int n, input int wb [8], input logic [15:0] ev [8],
                             input int nexp, input logic m, input int flip, input bit gaps);
        exp_t e;
        int   k;
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            vin[inst] = 1'b1;
            pin[inst] = px[i];
            md[inst]  = (i < flip) ? m : ~m;
            if (k < nexp && wb[k] == i) begin
                e.val = ev[k];
                e.cyc = cyc + 3;
                e.fd  = (k == nexp - 1);
                push(inst, e);
                k++;
            end
            @(negedge clk);
            vin[inst] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0;
            pin[i] = 16'd0;
            md[i]  = 1'b0;
        end
        for (int i = 0; i < 16; i++) px[i] = 16'(i);
        for (int i = 16; i < 32; i++) px[i] = 16'd0;
        if (MAXEN) begin
            ev_max_a = '{16'd10, 16'd11, 16'd14, 16'd15, 16'd0, 16'd0, 16'd0, 16'd0};
            ev_max_b = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd0, 16'd0, 16'd0, 16'd0};
        end else begin
            ev_max_a = '{16'd5, 16'd6, 16'd9, 16'd10, 16'd0, 16'd0, 16'd0, 16'd0};
            ev_max_b = '{16'd3, 16'd5, 16'd11, 16'd13, 16'd0, 16'd0, 16'd0, 16'd0};
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(0, po0, vo0, fd0);
        check_zero(1, po1, vo1, fd1);
        check_zero(2, po2, vo2, fd2);
        reset = 1'b1;
        @(negedge clk);

        // A: average then max on the 0..15 ramp
        run_frame(0, 16, '{10, 11, 14, 15, 0, 0, 0, 0},
                  '{16'd5, 16'd6, 16'd9, 16'd10, 16'd0, 16'd0, 16'd0, 16'd0}, 4, 1'b0, 16, 1'b0);
        run_frame(0, 16, '{10, 11, 14, 15, 0, 0, 0, 0}, ev_max_a, 4, 1'b1, 16, 1'b0);
        // B: K2 S2 max
        run_frame(1, 16, '{5, 7, 13, 15, 0, 0, 0, 0}, ev_max_b, 4, 1'b1, 16, 1'b0);

        // C: ch0 ramp, ch1 full scale, average with saturation
        for (int p = 0; p < 16; p++) begin
            px[2*p]   = 16'(p);
            px[2*p+1] = 16'hFFFF;
        end
        run_frame(2, 32, '{20, 21, 22, 23, 28, 29, 30, 31},
                  '{16'd5, 16'hFFFF, 16'd6, 16'hFFFF, 16'd9, 16'hFFFF, 16'd10, 16'hFFFF},
                  8, 1'b0, 32, 1'b0);
        for (int i = 0; i < 16; i++) px[i] = 16'(i);

        // A with random gaps; mode flips mid-frame and only takes effect next frame
        run_frame(0, 16, '{10, 11, 14, 15, 0, 0, 0, 0},
                  '{16'd5, 16'd6, 16'd9, 16'd10, 16'd0, 16'd0, 16'd0, 16'd0}, 4, 1'b0, 8, 1'b1);
        run_frame(0, 16, '{10, 11, 14, 15, 0, 0, 0, 0}, ev_max_a, 4, 1'b1, 8, 1'b1);

        // Partial frames, one with a result in flight, then reset
        run_frame(0, 9, '{0, 0, 0, 0, 0, 0, 0, 0},
                  '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 0, 1'b0, 16, 1'b0);
        run_frame(1, 6, '{0, 0, 0, 0, 0, 0, 0, 0},
                  '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 0, 1'b1, 16, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(0, po0, vo0, fd0);
        check_zero(1, po1, vo1, fd1);
        check_zero(2, po2, vo2, fd2);
        reset = 1'b1;
        @(negedge clk);
        run_frame(0, 16, '{10, 11, 14, 15, 0, 0, 0, 0},
                  '{16'd5, 16'd6, 16'd9, 16'd10, 16'd0, 16'd0, 16'd0, 16'd0}, 4, 1'b0, 16, 1'b0);
        run_frame(1, 16, '{5, 7, 13, 15, 0, 0, 0, 0}, ev_max_b, 4, 1'b1, 16, 1'b0);

        repeat (8) @(negedge clk);
        n_run += 3;
        if (q0.size() != 0) begin n_fail++; $display("FAIL drain_a: %0d outputs missing, required 0", q0.size()); end
        if (q1.size() != 0) begin n_fail++; $display("FAIL drain_b: %0d outputs missing, required 0", q1.size()); end
        if (q2.size() != 0) begin n_fail++; $display("FAIL drain_c: %0d outputs missing, required 0", q2.size()); end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
